qed_sif_controller: RTL and testbench

// - Sequencer for the SQED duplicate-execution flow on the steelcore QED datapath.
// - Gates original-instruction issue, switches the fetch mux to duplicates replayed from the QED instruction cache, and counts original and duplicate commits.
// - Raises sif_commit at the QED-consistent switch point and qed_check_valid once every duplicate has committed.
// - Drives dut.sif_state, sif_commit, qed_num_orig, qed_num_dup and qed_check_valid, which the formal harness constrains and checks.

---
 rtl/qed_sif_controller.sv | 146 ++++++++++++++
 tb/tb_qed_sif_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qed_sif_controller.sv
// SQED duplicate-execution sequencer: gates original issue, switches fetch to the
// duplicate stream, counts commits on both sides and flags protocol violations.
module qed_sif_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             exec_dup,
  input  logic             orig_issue,
  input  logic             commit_orig,
  input  logic             dup_issue,
  input  logic             commit_dup,
  output logic             orig_issue_ok,
  output logic             dup_sel,
  output logic             dup_issue_ok,
  output logic [2:0]       sif_state,
  output logic             sif_commit,
  output logic [CNT_W-1:0] qed_num_orig,
  output logic [CNT_W-1:0] qed_num_dup,
  output logic             qed_check_valid,
  output logic             qed_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ORIG  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DUP   = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] num_orig_q, num_orig_d;
  logic [CNT_W-1:0] num_dup_q, num_dup_d;
  logic [CNT_W-1:0] dup_issued_q, dup_issued_d;
  logic             sif_commit_q, sif_commit_d;
  logic             check_valid_q, check_valid_d;
  logic             err_q, err_d;
  logic             violation;
  logic             orig_phase;

  assign orig_issue_ok = (state_q == S_ORIG);
  assign dup_sel       = (state_q == S_DUP);
  assign dup_issue_ok  = (state_q == S_DUP) && (dup_issued_q < num_orig_q);
  assign orig_phase    = (state_q == S_ORIG) || (state_q == S_WAIT);

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    inflight_d   = inflight_q;
    num_orig_d   = num_orig_q;
    num_dup_d    = num_dup_q;
    dup_issued_d = dup_issued_q;
    err_d        = err_q;
    violation    = 1'b0;

    if (!ena || state_q == S_IDLE) begin
      // IDLE (or an abort into it) holds every counter and the error flag clear.
      state_d      = ena ? S_ORIG : S_IDLE;
      inflight_d   = CNT_ZERO;
      num_orig_d   = CNT_ZERO;
      num_dup_d    = CNT_ZERO;
      dup_issued_d = CNT_ZERO;
      err_d        = 1'b0;
    end else begin
      violation = (orig_issue && !orig_issue_ok) ||
                  (dup_issue && !dup_issue_ok) ||
                  (commit_orig && inflight_q == CNT_ZERO) ||
                  (commit_dup && state_q != S_DUP) ||
                  (commit_dup && num_dup_q == num_orig_q);

      if (orig_issue && !commit_orig && inflight_q != CNT_MAX) begin
        inflight_d = inflight_q + 1'b1;
      end else if (commit_orig && !orig_issue && inflight_q != CNT_ZERO) begin
        inflight_d = inflight_q - 1'b1;
      end

      if (commit_orig && orig_phase) begin
        if (num_orig_q == CNT_MAX) begin
          violation = 1'b1;
        end else begin
          num_orig_d = num_orig_q + 1'b1;
        end
      end

      if (dup_issue && dup_issued_q != CNT_MAX) begin
        dup_issued_d = dup_issued_q + 1'b1;
      end

      if (commit_dup && state_q == S_DUP && num_dup_q != CNT_MAX) begin
        num_dup_d = num_dup_q + 1'b1;
      end

      err_d = err_q | violation;

      case (state_q)
        S_ORIG:  if (exec_dup) state_d = S_WAIT;
        S_WAIT:  if (inflight_q == CNT_ZERO) begin
                   state_d = (num_orig_q != CNT_ZERO) ? S_DUP : S_ORIG;
                 end
        S_DUP:   if (num_dup_q == num_orig_q) state_d = S_CHECK;
        S_CHECK: state_d = S_CHECK;
        default: state_d = S_IDLE;
      endcase
    end

    sif_commit_d  = (state_d == S_DUP) || (state_d == S_CHECK);
    check_valid_d = (state_d == S_CHECK);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      inflight_q    <= CNT_ZERO;
      num_orig_q    <= CNT_ZERO;
      num_dup_q     <= CNT_ZERO;
      dup_issued_q  <= CNT_ZERO;
      sif_commit_q  <= 1'b0;
      check_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      num_orig_q    <= num_orig_d;
      num_dup_q     <= num_dup_d;
      dup_issued_q  <= dup_issued_d;
      sif_commit_q  <= sif_commit_d;
      check_valid_q <= check_valid_d;
      err_q         <= err_d;
    end
  end

  assign sif_state       = state_q;
  assign sif_commit      = sif_commit_q;
  assign qed_num_orig    = num_orig_q;
  assign qed_num_dup     = num_dup_q;
  assign qed_check_valid = check_valid_q;
  assign qed_err         = err_q;

endmodule

// File: tb/tb_qed_sif_controller.sv
// Bench for qed_sif_controller: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_qed_sif_controller;

  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, ena, exec_dup, orig_issue, commit_orig, dup_issue, commit_dup;
  logic             orig_issue_ok, dup_sel, dup_issue_ok;
  logic [2:0]       sif_state;
  logic             sif_commit;
  logic [CNT_W-1:0] qed_num_orig, qed_num_dup;
  logic             qed_check_valid, qed_err;

  int tests = 0;
  int fails = 0;

  qed_sif_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .exec_dup(exec_dup),
    .orig_issue(orig_issue), .commit_orig(commit_orig),
    .dup_issue(dup_issue), .commit_dup(commit_dup),
    .orig_issue_ok(orig_issue_ok), .dup_sel(dup_sel), .dup_issue_ok(dup_issue_ok),
    .sif_state(sif_state), .sif_commit(sif_commit),
    .qed_num_orig(qed_num_orig), .qed_num_dup(qed_num_dup),
    .qed_check_valid(qed_check_valid), .qed_err(qed_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0..4 = idle/orig/wait/dup/check, plain integer counts.
  int  m_phase, m_infl, m_norig, m_ndup, m_dissued;
  bit  m_err;

  function automatic int clampv(input int v);
    return (v < 0) ? 0 : ((v > MAXV) ? MAXV : v);
  endfunction

  task model_step();
    int  nxt;
    bit  bad;
    if (rst) begin
      m_phase = 0; m_infl = 0; m_norig = 0; m_ndup = 0; m_dissued = 0; m_err = 0;
    end else if (!ena || m_phase == 0) begin
      m_phase = ena ? 1 : 0;
      m_infl = 0; m_norig = 0; m_ndup = 0; m_dissued = 0; m_err = 0;
    end else begin
      bad = (orig_issue && m_phase != 1) ||
            (dup_issue && !(m_phase == 3 && m_dissued < m_norig)) ||
            (commit_orig && m_infl == 0) ||
            (commit_dup && m_phase != 3) ||
            (commit_dup && m_ndup == m_norig);
      case (m_phase)
        1:       nxt = exec_dup ? 2 : 1;
        2:       nxt = (m_infl != 0) ? 2 : ((m_norig != 0) ? 3 : 1);
        3:       nxt = (m_ndup == m_norig) ? 4 : 3;
        default: nxt = m_phase;
      endcase
      m_infl = clampv(m_infl + int'(orig_issue) - int'(commit_orig));
      if (commit_orig && (m_phase == 1 || m_phase == 2)) begin
        if (m_norig == MAXV) bad = 1;
        else m_norig++;
      end
      m_dissued = clampv(m_dissued + int'(dup_issue));
      if (commit_dup && m_phase == 3) m_ndup = clampv(m_ndup + 1);
      m_err   = m_err | bad;
      m_phase = nxt;
    end
  endtask

  // Compare process: update the model on the edge the DUT samples, check just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    check("sif_state", 32'(sif_state), m_phase);
    check("sif_commit", 32'(sif_commit), int'(m_phase == 3 || m_phase == 4));
    check("qed_check_valid", 32'(qed_check_valid), int'(m_phase == 4));
    check("qed_num_orig", 32'(qed_num_orig), m_norig);
    check("qed_num_dup", 32'(qed_num_dup), m_ndup);
    check("qed_err", 32'(qed_err), int'(m_err));
    check("orig_issue_ok", 32'(orig_issue_ok), int'(m_phase == 1));
    check("dup_sel", 32'(dup_sel), int'(m_phase == 3));
    check("dup_issue_ok", 32'(dup_issue_ok), int'(m_phase == 3 && m_dissued < m_norig));
  end

  // Apply one cycle of inputs and return at the following negedge.
  task automatic drive(input bit r, input bit e, input bit xd, input bit oi,
                       input bit co, input bit di, input bit cd);
    rst = r; ena = e; exec_dup = xd; orig_issue = oi;
    commit_orig = co; dup_issue = di; commit_dup = cd;
    @(negedge clk);
  endtask

  task automatic idle1();
    drive(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(sif_state), 0);
    check({tag, "_commit"}, 32'(sif_commit), 0);
    check({tag, "_norig"}, 32'(qed_num_orig), 0);
    check({tag, "_ndup"}, 32'(qed_num_dup), 0);
    check({tag, "_cv"}, 32'(qed_check_valid), 0);
    check({tag, "_err"}, 32'(qed_err), 0);
    check({tag, "_ok"}, 32'({orig_issue_ok, dup_sel, dup_issue_ok}), 0);
  endtask

  initial begin
    rst = 1; ena = 0; exec_dup = 0; orig_issue = 0;
    commit_orig = 0; dup_issue = 0; commit_dup = 0;
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    check_all_zero("reset");

    // Basic flow: 3 originals, then 3 duplicates.
    idle1();
    check("basic_orig_state", 32'(sif_state), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 0, 0);
      drive(0, 1, 0, 0, 1, 0, 0);
    end
    check("basic_norig", 32'(qed_num_orig), 3);
    drive(0, 1, 1, 0, 0, 0, 0);
    check("basic_wait_state", 32'(sif_state), 2);
    check("basic_commit_low", 32'(sif_commit), 0);
    idle1();
    check("basic_dup_state", 32'(sif_state), 3);
    check("basic_commit_rise", 32'(sif_commit), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 1, 0);
      drive(0, 1, 0, 0, 0, 0, 1);
    end
    check("basic_ndup", 32'(qed_num_dup), 3);
    check("basic_cv_t1", 32'(qed_check_valid), 0);
    idle1();
    check("basic_check_state", 32'(sif_state), 4);
    check("basic_cv_t2", 32'(qed_check_valid), 1);
    check("basic_err", 32'(qed_err), 0);

    drive(0, 0, 0, 0, 0, 0, 0);
    check_all_zero("ena_off_check");

    // Drain wait, then duplicate over-issue.
    idle1();
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    check("drain_wait", 32'(sif_state), 2);
    check("drain_issue_ok", 32'(orig_issue_ok), 0);
    idle1();
    check("drain_hold", 32'(sif_state), 2);
    drive(0, 1, 0, 0, 1, 0, 0);
    check("drain_hold1", 32'(sif_state), 2);
    drive(0, 1, 0, 0, 1, 0, 0);
    check("drain_hold2", 32'(sif_state), 2);
    idle1();
    check("drain_dup", 32'(sif_state), 3);
    check("drain_norig", 32'(qed_num_orig), 2);
    drive(0, 1, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 1, 0);
    check("over_ok_low", 32'(dup_issue_ok), 0);
    check("over_err_before", 32'(qed_err), 0);
    drive(0, 1, 0, 0, 0, 1, 0);
    check("over_err", 32'(qed_err), 1);

    // Empty original phase.
    drive(0, 0, 0, 0, 0, 0, 0);
    idle1();
    drive(0, 1, 1, 0, 0, 0, 0);
    check("empty_wait", 32'(sif_state), 2);
    idle1();
    check("empty_back_orig", 32'(sif_state), 1);
    check("empty_commit", 32'(sif_commit), 0);

    // Simultaneous issue and commit keep in-flight at 1.
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 1, 0, 0);
    check("simul_norig", 32'(qed_num_orig), 1);
    drive(0, 1, 0, 0, 1, 0, 0);
    check("simul_norig2", 32'(qed_num_orig), 2);
    check("simul_err", 32'(qed_err), 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    check("underflow_err", 32'(qed_err), 1);

    // Reset mid-DUP with 5 originals and 2 duplicates committed.
    drive(1, 0, 0, 0, 0, 0, 0);
    idle1();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 0, 0, 0);
      drive(0, 1, 0, 0, 1, 0, 0);
    end
    drive(0, 1, 1, 0, 0, 0, 0);
    idle1();
    drive(0, 1, 0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0, 1, 1);
    check("mid_state", 32'(sif_state), 3);
    check("mid_norig", 32'(qed_num_orig), 5);
    check("mid_ndup", 32'(qed_num_dup), 2);
    drive(1, 1, 0, 0, 0, 0, 0);
    check_all_zero("reset_dup");

    // Original-count saturation at all-ones.
    idle1();
    drive(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < MAXV; i++) drive(0, 1, 0, 1, 1, 0, 0);
    check("sat_full", 32'(qed_num_orig), MAXV);
    check("sat_err_before", 32'(qed_err), 0);
    drive(0, 1, 0, 1, 1, 0, 0);
    check("sat_hold", 32'(qed_num_orig), MAXV);
    check("sat_err", 32'(qed_err), 1);

    // Randomized traffic against the model.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(999) < 4, $urandom_range(99) < 98, $urandom_range(99) < 8,
            $urandom_range(99) < 35, $urandom_range(99) < 35,
            $urandom_range(99) < 35, $urandom_range(99) < 35);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
